alu_cmd_driver: RTL and testbench

Initiator side of the ALU operand/opcode interface. Accepts ALU commands on a valid/ready stream and buffers them in a small FIFO. Issues each command to the ALU as a single-cycle `ALU_en` pulse with operands held, waits a fixed ALU latency, captures `C`, and returns it on a valid/ready response stream. It sits between a command source (sequencer, CPU-side register block) and the ALU, which it treats as a fixed-latency responder.

---
 rtl/alu_cmd_driver_pkg.sv | 29 ++
 rtl/alu_cmd_fifo.sv | 50 +++++
 rtl/alu_cmd_driver.sv | 169 ++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_driver_pkg.sv
// Shared types for the ALU command driver: command record, FSM states
// and opcode field widths.
package alu_cmd_driver_pkg;

    localparam int A_OP_W = 3;
    localparam int B_OP_W = 2;

    // Operand width carried in the buffered command record. The driver's
    // IN_WIDTH is expected to match this value; widen it here to support
    // wider operands.
    localparam int CMD_IN_W = 5;

    typedef struct packed {
        logic signed [CMD_IN_W-1:0] a;
        logic signed [CMD_IN_W-1:0] b;
        logic                       a_en;
        logic                       b_en;
        logic [A_OP_W-1:0]          a_op;
        logic [B_OP_W-1:0]          b_op;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } drv_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate counter.
module alu_cmd_fifo
    import alu_cmd_driver_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  alu_cmd_t din,
    output alu_cmd_t head,
    output logic     full,
    output logic     empty
);

    localparam int PW = $clog2(DEPTH);

    alu_cmd_t       mem [DEPTH];
    logic [PW:0]    wr_ptr;
    logic [PW:0]    rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

    // Pointer update; a push is refused when full, a pop when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
            end
        end
    end

    // Storage write; contents need no reset because empty gates every read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[PW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator side of the ALU operand/opcode interface. Commands are buffered,
// issued one at a time as a single-cycle ALU_en pulse, and the result is
// captured after a fixed ALU latency and returned on a valid/ready stream.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds its payload stable until that edge.
//
// Optional feature macro: ALU_CMD_DRIVER_BYPASS_EN -- an idle driver with an
// empty FIFO issues an accepted command on the accept edge itself.
module alu_cmd_driver
    import alu_cmd_driver_pkg::*;
#(
    parameter int IN_WIDTH    = 5,
    parameter int OUT_WIDTH   = 6,
    parameter int FIFO_DEPTH  = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic signed [IN_WIDTH-1:0]  cmd_a,
    input  logic signed [IN_WIDTH-1:0]  cmd_b,
    input  logic                        cmd_a_en,
    input  logic                        cmd_b_en,
    input  logic [A_OP_W-1:0]           cmd_a_op,
    input  logic [B_OP_W-1:0]           cmd_b_op,
    output logic signed [IN_WIDTH-1:0]  A,
    output logic signed [IN_WIDTH-1:0]  B,
    output logic                        a_en,
    output logic                        b_en,
    output logic [A_OP_W-1:0]           a_op,
    output logic [B_OP_W-1:0]           b_op,
    output logic                        ALU_en,
    input  logic [OUT_WIDTH-1:0]        C,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [OUT_WIDTH-1:0]        rsp_c,
    output logic                        busy
);

    localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

    drv_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    alu_cmd_t            cmd_in, head, op_q;
    logic                fifo_full, fifo_empty;
    logic                cmd_fire, fifo_push, fifo_pop;
    logic                load_head, load_bypass, capture;
    logic                alu_en_q, rsp_valid_q;
    logic [OUT_WIDTH-1:0] rsp_c_q;

    assign cmd_ready = !fifo_full && !rst;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign busy      = !fifo_empty || (state_q != ST_IDLE);

    // Pack the incoming command fields into the buffered record.
    always_comb begin
        cmd_in      = '0;
        cmd_in.a    = CMD_IN_W'(cmd_a);
        cmd_in.b    = CMD_IN_W'(cmd_b);
        cmd_in.a_en = cmd_a_en;
        cmd_in.b_en = cmd_b_en;
        cmd_in.a_op = cmd_a_op;
        cmd_in.b_op = cmd_b_op;
    end

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (cmd_in),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state, latency counter and datapath strobes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fifo_push   = cmd_fire;
        fifo_pop    = 1'b0;
        load_head   = 1'b0;
        load_bypass = 1'b0;
        capture     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    load_head = 1'b1;
                    state_d   = ST_ISSUE;
                end
`ifdef ALU_CMD_DRIVER_BYPASS_EN
                else if (cmd_fire) begin
                    fifo_push   = 1'b0;
                    load_bypass = 1'b1;
                    state_d     = ST_ISSUE;
                end
`endif
            end
            ST_ISSUE: begin
                cnt_d   = CNT_W'(ALU_LATENCY - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        load_head = 1'b1;
                        state_d   = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and registered ALU / response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            alu_en_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_c_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            alu_en_q <= load_head || load_bypass;
            if (load_head) begin
                op_q <= head;
            end else if (load_bypass) begin
                op_q <= cmd_in;
            end
            if (capture) begin
                rsp_c_q     <= C;
                rsp_valid_q <= 1'b1;
            end else if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign A         = IN_WIDTH'(op_q.a);
    assign B         = IN_WIDTH'(op_q.b);
    assign a_en      = op_q.a_en;
    assign b_en      = op_q.b_en;
    assign a_op      = op_q.a_op;
    assign b_op      = op_q.b_op;
    assign ALU_en    = alu_en_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_c     = rsp_c_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: a fixed-latency ALU model answers the driver,
// and each accepted command's expected result is queued and compared when
// the driver returns a response.
module tb_alu_cmd_driver;

    localparam int IW    = 5;
    localparam int OW    = 6;
    localparam int DEPTH = 4;
    localparam int LAT   = 3;

    typedef struct {
        logic signed [IW-1:0] a;
        logic signed [IW-1:0] b;
        logic                 ae;
        logic                 be;
        logic [2:0]           aop;
        logic [1:0]           bop;
    } tcmd_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic signed [IW-1:0] cmd_a = '0, cmd_b = '0;
    logic                 cmd_a_en = 1'b0, cmd_b_en = 1'b0;
    logic [2:0]           cmd_a_op = '0;
    logic [1:0]           cmd_b_op = '0;
    logic signed [IW-1:0] A, B;
    logic                 a_en, b_en;
    logic [2:0]           a_op;
    logic [1:0]           b_op;
    logic                 ALU_en;
    logic [OW-1:0]        C;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [OW-1:0]        rsp_c;
    logic                 busy;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    logic [OW-1:0] exp_q[$];
    int          rsp_mode = 0;      // 0: ready low, 1: ready high, 2: random
    bit          chk_b2b = 1'b0;

    alu_cmd_driver #(
        .IN_WIDTH    (IW),
        .OUT_WIDTH   (OW),
        .FIFO_DEPTH  (DEPTH),
        .ALU_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_a_en  (cmd_a_en),
        .cmd_b_en  (cmd_b_en),
        .cmd_a_op  (cmd_a_op),
        .cmd_b_op  (cmd_b_op),
        .A         (A),
        .B         (B),
        .a_en      (a_en),
        .b_en      (b_en),
        .a_op      (a_op),
        .b_op      (b_op),
        .ALU_en    (ALU_en),
        .C         (C),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_c     (rsp_c),
        .busy      (busy)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Arbitrary ALU function used by both the ALU model and the expectations
    function automatic logic [OW-1:0] alu_fn(input logic signed [IW-1:0] a, input logic signed [IW-1:0] b,
                                             input logic ae, input logic be,
                                             input logic [2:0] aop, input logic [1:0] bop);
        return OW'(3 * int'(a) + int'(b) + 4 * int'(aop) + int'(bop) + (ae ? 7 : 0) + (be ? 11 : 0));
    endfunction

    // ALU model: samples ALU_en and operands at a rising edge, result valid
    // LAT cycles later; garbage is driven whenever no result is due.
    logic [OW-1:0] alu_pipe [LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= ALU_en ? alu_fn(A, B, a_en, b_en, a_op, b_op) : OW'($urandom);
        for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign C = alu_pipe[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Driver: offers a command from the current falling edge on; accepted
    // commands push their expected result. cmd_valid is left to the caller.
    task automatic send(input tcmd_t c, input int max_wait, output bit ok);
        ok        = 1'b0;
        cmd_a     = c.a;
        cmd_b     = c.b;
        cmd_a_en  = c.ae;
        cmd_b_en  = c.be;
        cmd_a_op  = c.aop;
        cmd_b_op  = c.bop;
        cmd_valid = 1'b1;
        for (int w = 0; w < max_wait; w++) begin
            if (cmd_ready) begin
                exp_q.push_back(alu_fn(c.a, c.b, c.ae, c.be, c.aop, c.bop));
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
    endtask

    function automatic tcmd_t rand_cmd();
        tcmd_t c;
        c.a   = IW'($urandom);
        c.b   = IW'($urandom);
        if ($urandom_range(0, 7) == 0) c.a = -16;
        if ($urandom_range(0, 7) == 0) c.b = 15;
        c.ae  = 1'($urandom);
        c.be  = 1'($urandom);
        c.aop = 3'($urandom);
        c.bop = 2'($urandom);
        return c;
    endfunction

    task automatic drain(input string name, input int max_cyc);
        for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) @(negedge clk);
        chk(name, exp_q.size(), 0);
    endtask

    // Response monitor: owns rsp_ready, compares every response handshake
    // against the head of exp_q, and checks stall stability and pulse shape.
    initial begin : monitor
        bit            prev_hold = 1'b0;
        bit            prev_en = 1'b0;
        bit            expect_issue = 1'b0;
        logic [OW-1:0] prev_c = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ALU_en) chk("alu_en_single_pulse", prev_en, 0);
                if (expect_issue) chk("issue_after_rsp", ALU_en, 1);
                expect_issue = 1'b0;
                if (prev_hold) begin
                    chk("rsp_valid_held", rsp_valid, 1);
                    chk("rsp_c_stable", rsp_c, prev_c);
                end
                case (rsp_mode)
                    0:       rsp_ready = 1'b0;
                    1:       rsp_ready = 1'b1;
                    default: rsp_ready = 1'($urandom_range(0, 1));
                endcase
                prev_hold = 1'b0;
                if (rsp_valid) begin
                    if (rsp_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_rsp: got %0h expected no response (cycle %0d)", rsp_c, cyc);
                        end else begin
                            if (chk_b2b && exp_q.size() > 1) expect_issue = 1'b1;
                            chk("rsp_c", rsp_c, exp_q.pop_front());
                        end
                    end else begin
                        prev_hold = 1'b1;
                        prev_c    = rsp_c;
                    end
                end
                prev_en = ALU_en;
            end else begin
                prev_hold    = 1'b0;
                prev_en      = 1'b0;
                expect_issue = 1'b0;
                rsp_ready    = 1'b0;
            end
        end
    end

    // Single command from an idle driver: pulse timing, pins, capture edge.
    task automatic lat_test(input tcmd_t c, input string tag);
        int unsigned e;
        int          t_en, t_rv, en_cnt;
        logic signed [IW-1:0] ra, rb;
        logic        rae, rbe;
        logic [2:0]  raop;
        logic [1:0]  rbop;
        bit          ok;
        int unsigned exp_en, exp_rv;
        t_en = -1; t_rv = -1; en_cnt = 0;
        ra = '0; rb = '0; rae = 1'b0; rbe = 1'b0; raop = '0; rbop = '0;
        rsp_mode = 1;
        e = cyc + 1;
        send(c, 1, ok);
        cmd_valid = 1'b0;
        chk({tag, "_accept"}, ok, 1);
        for (int i = 0; i < 20 && t_rv < 0; i++) begin
            if (i > 0) @(negedge clk);
            if (ALU_en) begin
                en_cnt++;
                if (t_en < 0) begin
                    t_en = int'(cyc);
                    ra = A; rb = B; rae = a_en; rbe = b_en; raop = a_op; rbop = b_op;
                end
            end
            if (rsp_valid) t_rv = int'(cyc);
        end
`ifdef ALU_CMD_DRIVER_BYPASS_EN
        exp_en = e;
        exp_rv = e + 1 + LAT;
`else
        exp_en = e + 1;
        exp_rv = e + 2 + LAT;
`endif
        chk({tag, "_alu_en_cycle"}, t_en, exp_en);
        chk({tag, "_alu_en_count"}, en_cnt, 1);
        chk({tag, "_rsp_valid_cycle"}, t_rv, exp_rv);
        chk({tag, "_pin_A"}, ra, c.a);
        chk({tag, "_pin_B"}, rb, c.b);
        chk({tag, "_pin_a_en"}, rae, c.ae);
        chk({tag, "_pin_b_en"}, rbe, c.be);
        chk({tag, "_pin_a_op"}, raop, c.aop);
        chk({tag, "_pin_b_op"}, rbop, c.bop);
        drain({tag, "_drain"}, 20);
        @(negedge clk);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_A_retained"}, A, c.a);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        tcmd_t c;
        bit    ok;
        int    accepted;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_A", A, 0);
        chk("rst_B", B, 0);
        chk("rst_a_en", a_en, 0);
        chk("rst_b_en", b_en, 0);
        chk("rst_a_op", a_op, 0);
        chk("rst_b_op", b_op, 0);
        chk("rst_alu_en", ALU_en, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_c", rsp_c, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);
        @(negedge clk);

        // Directed single commands
        c = '{a: 5'sd3, b: 5'sd2, ae: 1'b1, be: 1'b0, aop: 3'd1, bop: 2'd0};
        lat_test(c, "single");
        c = '{a: -5'sd16, b: 5'sd15, ae: 1'b1, be: 1'b1, aop: 3'd7, bop: 2'd3};
        lat_test(c, "extreme");

        // Random traffic with random response back-pressure
        rsp_mode = 2;
        for (int n = 0; n < 40; n++) begin
            send(rand_cmd(), 300, ok);
            chk("rand_accept", ok, 1);
            if ($urandom_range(0, 3) == 0) begin
                cmd_valid = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        drain("rand_drain", 600);

        // Stall: response held, FIFO fills to DEPTH plus the one in flight
        rsp_mode = 0;
        repeat (2) @(negedge clk);
        accepted = 0;
        for (int n = 0; n < DEPTH + 1; n++) begin
            send(rand_cmd(), 1, ok);
            if (ok) accepted++;
        end
        chk("stall_accepts", accepted, DEPTH + 1);
        send(rand_cmd(), 8, ok);
        cmd_valid = 1'b0;
        chk("stall_full_refuses", ok, 0);
        chk("stall_cmd_ready", cmd_ready, 0);
        chk("stall_rsp_valid", rsp_valid, 1);
        chk("stall_busy", busy, 1);
        chk_b2b  = 1'b1;
        rsp_mode = 1;
        drain("stall_drain", 200);
        @(negedge clk);
        chk("stall_busy_after", busy, 0);
        chk_b2b = 1'b0;

        // Reset while a command is in WAIT with more queued
        rsp_mode = 0;
        for (int n = 0; n < 3; n++) send(rand_cmd(), 5, ok);
        cmd_valid = 1'b0;
        for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
        chk("mid_first_hold", rsp_valid, 1);
        rsp_mode = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ALU_en && !rsp_valid) break;
        end
        chk("mid_reissue", ALU_en, 1);
        @(negedge clk);
        chk("mid_wait_alu_en_low", ALU_en, 0);
        chk("mid_wait_no_rsp", rsp_valid, 0);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_alu_en", ALU_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        chk("mid_rst_A", A, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_rst_quiet_busy", busy, 0);
        chk("mid_rst_quiet_rsp", rsp_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
